alu_md_seq: RTL and testbench
=============================

// Module: alu_md_seq
// PURPOSE
//   Parametrised, registered successor to the 32-bit combinational ALU. It runs the same 14 MIPS-style ALU ops
//   with a 1-cycle registered latency, and adds iterative MULT/MULTU/DIV/DIVU that produce HI/LO results.
//   Operands and results move over valid/ready handshakes. It sits between the decode/operand stage and writeback.
// PARAMETERS
//   WIDTH   32  datapath width; power of 2, >=8; shift amount = a[$clog2(WIDTH)-1:0]
//   MD_EN   1   1 = mult/div codes enabled; 0 = mult/div codes treated as reserved
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands/opcode valid
//   in_ready   out  1      block can accept; transfer when in_valid&in_ready
//   aluc       in   5      opcode (see BEHAVIOUR)
//   a          in   WIDTH  operand A (shift amount for shifts)
//   b          in   WIDTH  operand B
//   out_valid  out  1      result registers valid
//   out_ready  in   1      consumer accepts; result retires when out_valid&out_ready
//   r          out  WIDTH  result (mult: low half; div: quotient)
//   hi         out  WIDTH  mult: high half; div: remainder; ALU ops: 0
//   lo         out  WIDTH  mult: low half; div: quotient; ALU ops: 0
//   zero       out  1      r==0
//   carry      out  1      carry/borrow/last-shifted-out bit
//   negative   out  1      see per-op rules
//   overflow   out  1      signed overflow / DIV MIN/-1
//   div_zero   out  1      divide by zero occurred
// BEHAVIOUR
//   Reset: state IDLE; out_valid, r, hi, lo and all flags = 0; in_ready = 0 while rst is high.
//   Opcodes, aluc[4]=0:
//     0000 addu, 0010 add, 0001 subu, 0011 sub, 0100 and, 0101 or, 0110 xor, 0111 nor
//     100x lui = {b[WIDTH/2-1:0], 0}, 1011 slt, 1010 sltu, 1100 sra(b>>>sh), 111x sll(b<<sh), 1101 srl(b>>sh)
//   Opcodes, aluc[4]=1: 10000 multu, 10001 mult, 10010 divu, 10011 div.
//     Other codes, or any aluc[4]=1 when MD_EN=0, are reserved: r=hi=lo=0, zero=1, other flags 0, latency 1.
//   Flags never take X or Z. Inapplicable flags = 0.
//     addu: carry = bit WIDTH of the {0,a}+{0,b} sum.
//     subu: carry = borrow (a<b unsigned).
//     add/sub: overflow = signed overflow of that same op. For sub: a,b signs differ and r sign != a sign.
//     slt: negative = true sign of a-b, i.e. (a<b signed).
//     shifts: carry = last bit shifted out; carry = 0 when sh=0. negative = r[WIDTH-1] for all logic, shift and add ops.
//   in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back ALU ops sustain 1 op per cycle.
//   FSM: IDLE -> (accept ALU op) IDLE, results registered at the accept edge, out_valid=1 next cycle.
//     IDLE -> (accept mult/div, MD_EN=1) BUSY, counter=0. BUSY runs WIDTH iterations (1 bit/cycle).
//     BUSY -> FIX (1 cycle: sign correction) -> IDLE with out_valid=1.
//     The out_valid rise comes WIDTH+2 cycles after the accept edge.
//   Mult: {hi,lo} = full 2*WIDTH product, signed or unsigned; r = lo; zero = (hi==0 && lo==0).
//   Div: quotient truncates toward zero; remainder takes the sign of a.
//     b==0: lo=r = all ones, hi = a, div_zero = 1, still takes the full latency.
//     div with a=MIN, b=-1: lo=r=MIN, hi=0, overflow=1.
//   out_valid holds with r/hi/lo/flags stable until out_ready; with no new accept, out_valid clears after retire.
//   Inputs are ignored while BUSY/FIX. Operands are latched at accept, so later changes to a/b have no effect.
//   rst mid-operation aborts: no result is produced, and the FSM returns to IDLE.
// TESTING  (WIDTH=32)
//   add a=7FFFFFFF b=1 -> r=80000000 overflow=1 negative=1; addu FFFFFFFF+1 -> r=0 zero=1 carry=1
//   sra a=4 b=F0000008 -> r=FF000000 carry=1; sll a=0 b=5 -> r=5 carry=0; sltu a=1 b=FFFFFFFF -> r=1
//   mult a=FFFFFFFE(-2) b=3 -> hi=FFFFFFFF lo=FFFFFFFA, out_valid exactly 34 cycles after accept
//   div a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF; divu a=5 b=0 -> lo=FFFFFFFF hi=5 div_zero=1
//   out_ready=0 for 5 cycles after an add -> out_valid, r held stable, in_ready=0; 10 back-to-back addu -> 10 results in 10 cycles
//   rst at cycle 10 of a divu -> out_valid stays 0, in_ready=1 the cycle after rst drops; next addu correct

Source files
------------

// File: rtl/alu_md_seq.sv
// Registered MIPS-style ALU with iterative multiply/divide behind valid/ready handshakes.
// ALU ops retire one cycle after accept; mult/div retire WIDTH+2 cycles after accept.
module alu_md_seq #(
  parameter int WIDTH = 32,
  parameter bit MD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       aluc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             div_zero
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_e;
  typedef enum logic [1:0] {MD_MULTU, MD_MULT, MD_DIVU, MD_DIV} md_op_e;

  state_e           state_q;
  md_op_e           md_op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;              // raw operands, kept for signs and divide-by-zero
  logic [WIDTH-1:0] acc_q, lsw_q, opb_q;   // high/remainder, low/quotient, multiplicand/divisor
  logic [WIDTH-1:0] r_q, hi_q, lo_q;
  logic             out_valid_q, zero_q, carry_q, negative_q, overflow_q, div_zero_q;

  logic accept, is_md;
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !rst;
  assign accept   = in_valid && in_ready;
  assign is_md    = MD_EN && aluc[4] && (aluc[3:2] == 2'b00);

  // Single-cycle ALU path
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sum_ext, dif_ext, sll_ext, srl_ext, sra_ext;
  logic [WIDTH-1:0] alu_r;
  logic             alu_carry, alu_neg, alu_ovf, slt_res;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    alu_r     = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    sh        = a[SHW-1:0];
    sum_ext   = {1'b0, a} + {1'b0, b};
    dif_ext   = {1'b0, a} - {1'b0, b};
    sll_ext   = {1'b0, b} << sh;
    srl_ext   = {b, 1'b0} >> sh;
    sra_ext   = $signed({b, 1'b0}) >>> sh;
    slt_res   = $signed(a) < $signed(b);
    if (!aluc[4]) begin
      case (aluc[3:0])
        4'b0000: begin alu_r = sum_ext[MSB:0]; alu_carry = sum_ext[WIDTH]; end
        4'b0010: begin
          alu_r   = sum_ext[MSB:0];
          alu_ovf = (a[MSB] == b[MSB]) && (alu_r[MSB] != a[MSB]);
        end
        4'b0001: begin alu_r = dif_ext[MSB:0]; alu_carry = dif_ext[WIDTH]; end
        4'b0011: begin
          alu_r   = dif_ext[MSB:0];
          alu_ovf = (a[MSB] != b[MSB]) && (alu_r[MSB] != a[MSB]);
        end
        4'b0100: alu_r = a & b;
        4'b0101: alu_r = a | b;
        4'b0110: alu_r = a ^ b;
        4'b0111: alu_r = ~(a | b);
        4'b1000, 4'b1001: alu_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
        4'b1010: alu_r = {{(WIDTH-1){1'b0}}, dif_ext[WIDTH]};
        4'b1011: alu_r = {{(WIDTH-1){1'b0}}, slt_res};
        4'b1100: begin alu_r = sra_ext[WIDTH:1]; alu_carry = sra_ext[0]; end
        4'b1101: begin alu_r = srl_ext[WIDTH:1]; alu_carry = srl_ext[0]; end
        default: begin alu_r = sll_ext[MSB:0]; alu_carry = sll_ext[WIDTH]; end
      endcase
    end
    alu_neg = (!aluc[4] && aluc[3:0] == 4'b1011) ? slt_res : alu_r[MSB];
  end

  // Iterative mult/div step and final sign correction
  logic                 signed_md, is_mult, a_neg, b_neg, rem_ge;
  logic [WIDTH-1:0]     a_mag, b_mag, acc_d, lsw_d, rem_sub, quo, rem, fix_hi, fix_lo;
  logic [WIDTH:0]       mul_sum, rem_sh;
  logic [2*WIDTH-1:0]   prod;
  logic                 fix_zero, fix_ovf, fix_dz;

  always_comb begin
    signed_md = (md_op_q == MD_MULT) || (md_op_q == MD_DIV);
    is_mult   = !md_op_q[1];
    a_neg     = signed_md && a_q[MSB];
    b_neg     = signed_md && b_q[MSB];
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -b_q : b_q;
    mul_sum   = {1'b0, acc_q} + (lsw_q[0] ? {1'b0, opb_q} : '0);
    rem_sh    = {acc_q, lsw_q[MSB]};
    rem_ge    = rem_sh >= {1'b0, opb_q};
    rem_sub   = rem_sh[MSB:0] - opb_q;
    if (is_mult) begin
      acc_d = mul_sum[WIDTH:1];
      lsw_d = {mul_sum[0], lsw_q[MSB:1]};
    end else begin
      acc_d = rem_ge ? rem_sub : rem_sh[MSB:0];
      lsw_d = {lsw_q[MSB-1:0], rem_ge};
    end
    prod    = (a_neg ^ b_neg) ? -{acc_q, lsw_q} : {acc_q, lsw_q};
    quo     = (a_neg ^ b_neg) ? -lsw_q : lsw_q;
    rem     = a_neg ? -acc_q : acc_q;
    fix_ovf = 1'b0;
    fix_dz  = 1'b0;
    if (is_mult) begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[MSB:0];
    end else if (b_q == '0) begin
      fix_hi = a_q;
      fix_lo = '1;
      fix_dz = 1'b1;
    end else begin
      // MIN / -1 wraps back to MIN through the magnitude path; only the flag is extra.
      fix_hi  = rem;
      fix_lo  = quo;
      fix_ovf = signed_md && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    end
    fix_zero = is_mult ? (prod == '0) : (fix_lo == '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      md_op_q     <= MD_MULTU;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      lsw_q       <= '0;
      opb_q       <= '0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          if (is_md) begin
            state_q <= S_BUSY;
            cnt_q   <= '0;
            md_op_q <= md_op_e'(aluc[1:0]);
            a_q     <= a;
            b_q     <= b;
          end else begin
            out_valid_q <= 1'b1;
            r_q         <= alu_r;
            hi_q        <= '0;
            lo_q        <= '0;
            zero_q      <= (alu_r == '0);
            carry_q     <= alu_carry;
            negative_q  <= alu_neg;
            overflow_q  <= alu_ovf;
            div_zero_q  <= 1'b0;
          end
        end
        S_BUSY: begin
          // Count 0 conditions the operands to magnitudes; counts 1..WIDTH iterate.
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == '0) begin
            acc_q <= '0;
            lsw_q <= a_mag;
            opb_q <= b_mag;
          end else begin
            acc_q <= acc_d;
            lsw_q <= lsw_d;
          end
          if (cnt_q == CW'(WIDTH)) state_q <= S_FIX;
        end
        S_FIX: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b1;
          r_q         <= fix_lo;
          hi_q        <= fix_hi;
          lo_q        <= fix_lo;
          zero_q      <= fix_zero;
          carry_q     <= 1'b0;
          negative_q  <= 1'b0;
          overflow_q  <= fix_ovf;
          div_zero_q  <= fix_dz;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;
  assign div_zero  = div_zero_q;
endmodule

// File: tb/tb_alu_md_seq.sv
// Directed self-checking bench for alu_md_seq (WIDTH=32, MD_EN=1) with hand-computed expectations.
module tb_alu_md_seq;
  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  aluc;
  logic [31:0] a, b, r, hi, lo;
  logic        zero, carry, negative, overflow, div_zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_md_seq #(.WIDTH(32), .MD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .aluc(aluc),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .r(r), .hi(hi), .lo(lo),
    .zero(zero), .carry(carry), .negative(negative), .overflow(overflow), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Flags are packed {zero, carry, negative, overflow, div_zero}.
  task automatic check_alu(input string tag, input logic [31:0] er, input logic [4:0] ef);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".r"}, 64'(r), 64'(er));
    check({tag, ".hilo"}, {hi, lo}, 64'd0);
    check({tag, ".flags"}, 64'({zero, carry, negative, overflow, div_zero}), 64'(ef));
  endtask

  // Negative is not defined for mult/div, so it is left out of the flag compare.
  task automatic check_md(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic [3:0] ef);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".hilo"}, {hi, lo}, {ehi, elo});
    check({tag, ".r"}, 64'(r), 64'(elo));
    check({tag, ".flags"}, 64'({zero, carry, overflow, div_zero}), 64'(ef));
  endtask

  // Presents one op at a negedge, lets it be accepted, returns at the following negedge.
  task automatic issue(input logic [4:0] op, input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    aluc = op; a = aa; b = bb; in_valid = 1'b1;
    check("issue.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) check("wait_valid.timeout", 64'(out_valid), 64'd1);
  endtask

  int lat, seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; aluc = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd0);
    check("reset.r_hi_lo", {r, hi | lo}, 64'd0);
    check("reset.flags", 64'({zero, carry, negative, overflow, div_zero}), 64'd0);
    rst = 1'b0;
    #1 check("reset.in_ready_after", 64'(in_ready), 64'd1);

    issue(5'b00010, 32'h7FFF_FFFF, 32'h1);  check_alu("add_ovf",  32'h8000_0000, 5'b00110);
    issue(5'b00000, 32'hFFFF_FFFF, 32'h1);  check_alu("addu_cy",  32'h0,         5'b11000);
    issue(5'b01100, 32'h4, 32'hF000_0008);  check_alu("sra",      32'hFF00_0000, 5'b01100);
    issue(5'b01110, 32'h0, 32'h5);          check_alu("sll0",     32'h5,         5'b00000);
    issue(5'b01010, 32'h1, 32'hFFFF_FFFF);  check_alu("sltu",     32'h1,         5'b00000);
    issue(5'b01011, 32'hFFFF_FFFF, 32'h1);  check_alu("slt",      32'h1,         5'b00100);
    issue(5'b00011, 32'h8000_0000, 32'h1);  check_alu("sub_ovf",  32'h7FFF_FFFF, 5'b00010);
    issue(5'b00001, 32'h1, 32'h2);          check_alu("subu_bor", 32'hFFFF_FFFF, 5'b01100);
    issue(5'b01000, 32'h0, 32'h0000_ABCD);  check_alu("lui",      32'hABCD_0000, 5'b00100);
    issue(5'b01101, 32'h1, 32'h3);          check_alu("srl",      32'h1,         5'b01000);
    issue(5'b00111, 32'h0, 32'h0);          check_alu("nor",      32'hFFFF_FFFF, 5'b00100);
    issue(5'b10100, 32'h1234, 32'h5678);    check_alu("reserved", 32'h0,         5'b10000);

    // Signed mult; operands change and in_valid stays low while busy, result must not move.
    issue(5'b10001, 32'hFFFF_FFFE, 32'h3);
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    check("mult.busy_in_ready", 64'(in_ready), 64'd0);
    wait_valid(lat);
    check("mult.latency", 64'(lat), 64'd34);
    check_md("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 4'b0000);

    issue(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_valid(lat);
    check_md("multu", 32'hFFFF_FFFE, 32'h0000_0001, 4'b0000);
    issue(5'b10011, 32'hFFFF_FFF9, 32'h2); wait_valid(lat);
    check_md("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 4'b0000);
    issue(5'b10010, 32'h5, 32'h0); wait_valid(lat);
    check("divu_zero.latency", 64'(lat), 64'd34);
    check_md("divu_zero", 32'h5, 32'hFFFF_FFFF, 4'b0001);
    issue(5'b10011, 32'h8000_0000, 32'hFFFF_FFFF); wait_valid(lat);
    check_md("div_min", 32'h0, 32'h8000_0000, 4'b0010);
    issue(5'b10010, 32'd100, 32'd7); wait_valid(lat);
    check_md("divu", 32'd2, 32'd14, 4'b0000);

    // Backpressure: result and out_valid hold, no new accept possible.
    @(negedge clk);
    out_ready = 1'b0;
    issue(5'b00010, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", 64'(out_valid), 64'd1);
      check("bp.r", 64'(r), 64'd7);
      check("bp.in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.retired", 64'(out_valid), 64'd0);

    // Ten back-to-back addu: one result per cycle.
    aluc = 5'b00000; a = 32'd0; b = 32'd100; in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid && r == 32'(i + 100)) seen++;
      check("b2b.r", 64'(r), 64'(i + 100));
      if (i < 9) a = 32'(i + 1);
      else in_valid = 1'b0;
    end
    check("b2b.count", 64'(seen), 64'd10);
    @(negedge clk);
    check("b2b.drained", 64'(out_valid), 64'd0);

    // Reset in the middle of a divu aborts it.
    issue(5'b10010, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("abort.in_ready", 64'(in_ready), 64'd1);
    check("abort.out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort.no_result", 64'(seen), 64'd0);
    issue(5'b00000, 32'd2, 32'd3);
    check_alu("abort.next_addu", 32'd5, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
